// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a byte-wide register bank with pointer auto-increment.
// SCL/SDA are oversampled, synchronised and glitch-filtered in the clk domain.
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR    = 7'h2d,
    parameter int         REG_NUM     = 16,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_CYC    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 scl,
    inout  wire                  sda,
    output logic [8*REG_NUM-1:0] reg_out,
    output logic                 wr_stb,
    output logic [7:0]           wr_idx,
    output logic                 busy
);

    localparam int            IW        = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int            FW        = $clog2(FILT_CYC + 1);
    localparam logic [8:0]    REG_NUM9  = 9'(REG_NUM);
    localparam logic [7:0]    PTR_MAX   = 8'(REG_NUM - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [1:0]             raw_s, filt_q, filt_d;
    logic [FW-1:0]          filt_cnt [2];

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh, ptr, rx_byte, cur_reg;
    logic       rw_q, sda_oe;
    logic [7:0] regs [REG_NUM];

    logic oe_n, busy_n, cnt_clr, cnt_inc, rx_shift, tx_load, tx_shift;
    logic ptr_load, ptr_inc, reg_wr, rw_load;

    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign raw_s = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

    // A new level is accepted only after FILT_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_q      <= '1;
            filt_d      <= '1;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            filt_d <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (raw_s[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    filt_q[i]   <= raw_s[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f     = filt_q[1];
    assign sda_f     = filt_q[0];
    assign scl_rise  = scl_f & ~filt_d[1];
    assign scl_fall  = ~scl_f & filt_d[1];
    assign start_det = scl_f & filt_d[1] & filt_d[0] & ~sda_f;
    assign stop_det  = scl_f & filt_d[1] & ~filt_d[0] & sda_f;

    assign rx_byte = {rx_sh[6:0], sda_f};
    assign cur_reg = regs[ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n  = state;
        oe_n     = sda_oe;
        busy_n   = busy;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        rx_shift = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        reg_wr   = 1'b0;
        rw_load  = 1'b0;

        if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            cnt_clr = 1'b1;
        end else if (start_det) begin
            state_n = ADDR;
            oe_n    = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                ADDR: if (scl_rise) begin
                    rx_shift = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        cnt_clr = 1'b1;
                        if (rx_byte[7:1] == SLV_ADDR) begin
                            state_n = ADDR_ACK;
                            rw_load = 1'b1;
                        end else begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                PTR: if (scl_rise) begin
                    rx_shift = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        cnt_clr = 1'b1;
                        if ({1'b0, rx_byte} < REG_NUM9) begin
                            ptr_load = 1'b1;
                            state_n  = PTR_ACK;
                        end else begin
                            state_n  = IGNORE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                WDATA: if (scl_rise) begin
                    rx_shift = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        cnt_clr = 1'b1;
                        reg_wr  = 1'b1;
                        ptr_inc = 1'b1;
                        state_n = WDATA_ACK;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                // First falling edge starts the ACK pulse, the second ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        oe_n    = 1'b1;
                        cnt_inc = 1'b1;
                        if (state == ADDR_ACK) busy_n = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                        oe_n    = 1'b0;
                        if (state != ADDR_ACK) begin
                            state_n = WDATA;
                        end else if (rw_q) begin
                            state_n = RDATA;
                            tx_load = 1'b1;
                            oe_n    = ~cur_reg[7];
                        end else begin
                            state_n = PTR;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_inc = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n = RACK;
                            oe_n    = 1'b0;
                            cnt_clr = 1'b1;
                        end else begin
                            tx_shift = 1'b1;
                            oe_n     = ~tx_sh[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && bit_cnt == 4'd0) begin
                        ptr_inc = 1'b1;
                        if (sda_f) state_n = IGNORE;
                        else       cnt_inc = 1'b1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n = RDATA;
                        cnt_clr = 1'b1;
                        tx_load = 1'b1;
                        oe_n    = ~cur_reg[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            ptr     <= '0;
            rw_q    <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            // NOTE: the register bank is architecturally visible, so it is reset
            // like any other state rather than left as uninitialised memory.
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            sda_oe <= oe_n;
            busy   <= busy_n;
            wr_stb <= reg_wr;

            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;

            if (rx_shift) rx_sh <= rx_byte;

            if (tx_load)       tx_sh <= cur_reg;
            else if (tx_shift) tx_sh <= {tx_sh[6:0], 1'b0};

            if (rw_load) rw_q <= rx_byte[0];

            if (ptr_load)     ptr <= rx_byte;
            else if (ptr_inc) ptr <= (ptr == PTR_MAX) ? 8'd0 : ptr + 8'd1;

            if (reg_wr) begin
                regs[ptr[IW-1:0]] <= rx_byte;
                wr_idx            <= ptr;
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_img
        assign reg_out[8*g +: 8] = regs[g];
    end

    // Open drain: pull low or release, never drive high.
    assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed and randomised bus transactions against a transaction-level
// register-bank model; each comparison is an immediate assertion.
module tb_i2c_slave_regfile;

    localparam int         REG_NUM = 16;
    localparam logic [6:0] SLV     = 7'h2d;
    localparam int         Q       = 8;

    logic                 clk   = 1'b0;
    logic                 rstn  = 1'b0;
    logic                 scl   = 1'b1;
    logic                 m_low = 1'b0;
    wire                  sda_bus;
    logic [8*REG_NUM-1:0] reg_out;
    logic                 wr_stb;
    logic [7:0]           wr_idx;
    logic                 busy;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .SLV_ADDR(SLV), .REG_NUM(REG_NUM), .SYNC_STAGES(2), .FILT_CYC(3)
    ) dut (
        .clk(clk), .rstn(rstn), .scl(scl), .sda(sda_bus),
        .reg_out(reg_out), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
    );

    // Reference model: register contents and pointer at transaction level.
    logic [7:0] mreg [REG_NUM];
    int         mptr;
    logic [7:0] wbuf [8];
    bit         glitch_en = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] stb_idx_q [$];
    logic [7:0] stb_dat_q [$];
    int         stb_long  = 0;
    bit         stb_prev  = 1'b0;
    bit         busy_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_idx_q.push_back(wr_idx);
            stb_dat_q.push_back(reg_out[int'(wr_idx)*8 +: 8]);
            if (stb_prev) stb_long++;
        end
        stb_prev = wr_stb;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [127:0] mp;
        for (int i = 0; i < REG_NUM; i++) mp[i*8 +: 8] = mreg[i];
        check({tag, ".regs"}, reg_out, mp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) mreg[i] = 8'h00;
        mptr = 0;
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wq();
        scl   = 1'b1; wq();
        m_low = 1'b1; wq();
        scl   = 1'b0; wq();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wq();
        scl   = 1'b1; wq();
        m_low = 1'b0; wq();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_low = ~b; wq();
        scl   = 1'b1; wq();
        s     = sda_bus; wq();
        scl   = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    task automatic clear_mon();
        stb_idx_q.delete();
        stb_dat_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic xfer_write(input string tag, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] exp_idx [$];
        logic [7:0] exp_dat [$];
        bit         ok_ptr;
        ok_ptr = int'(p) < REG_NUM;
        clear_mon();
        bus_start();
        write_byte({SLV, 1'b0}, ack);
        check({tag, ".addr_ack"}, ack, 0);
        write_byte(p, ack);
        check({tag, ".ptr_ack"}, ack, ok_ptr ? 0 : 1);
        if (ok_ptr) mptr = int'(p);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            if (ok_ptr) begin
                check({tag, ".data_ack"}, ack, 0);
                exp_idx.push_back(8'(mptr));
                exp_dat.push_back(wbuf[i]);
                mreg[mptr] = wbuf[i];
                mptr = (mptr + 1) % REG_NUM;
            end else begin
                check({tag, ".data_nack"}, ack, 1);
            end
            if (glitch_en) begin
                scl = 1'b1;
                repeat (2) @(negedge clk);
                scl = 1'b0;
                wq();
            end
        end
        bus_stop();
        wq();
        check({tag, ".busy_lo"}, busy, 0);
        check({tag, ".stb_cnt"}, stb_idx_q.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (i < stb_idx_q.size()) begin
                check({tag, ".stb_idx"}, stb_idx_q[i], exp_idx[i]);
                check({tag, ".stb_dat"}, stb_dat_q[i], exp_dat[i]);
            end
        end
        check_regs(tag);
    endtask

    task automatic xfer_read(input string tag, input bit use_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (use_ptr) begin
            write_byte({SLV, 1'b0}, ack);
            check({tag, ".waddr_ack"}, ack, 0);
            write_byte(p, ack);
            check({tag, ".ptr_ack"}, ack, 0);
            mptr = int'(p);
            bus_start();
        end
        write_byte({SLV, 1'b1}, ack);
        check({tag, ".raddr_ack"}, ack, 0);
        check({tag, ".busy_hi"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check({tag, ".data"}, d, mreg[mptr]);
            mptr = (mptr + 1) % REG_NUM;
        end
        check({tag, ".sda_rel"}, sda_bus, 1);
        bus_stop();
        wq();
        check({tag, ".busy_lo"}, busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ack;
        logic s;

        model_reset();
        repeat (4) @(negedge clk);
        check("reset.reg_out", reg_out, 0);
        check("reset.busy", busy, 0);
        check("reset.wr_stb", wr_stb, 0);
        check("reset.wr_idx", wr_idx, 0);
        check("reset.sda", sda_bus, 1);
        rstn = 1'b1;
        wq();

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        xfer_write("wr_inc", 8'h03, 2);
        check("wr_inc.reg3", reg_out[3*8 +: 8], 8'hA5);
        check("wr_inc.reg4", reg_out[4*8 +: 8], 8'h3C);

        xfer_read("rd_sr", 1'b1, 8'h03, 2);

        clear_mon();
        bus_start();
        write_byte(8'hB6, ack);
        check("mism.addr_nack", ack, 1);
        write_byte(8'h01, ack);
        check("mism.byte1_nack", ack, 1);
        write_byte(8'h77, ack);
        check("mism.byte2_nack", ack, 1);
        bus_stop();
        wq();
        check("mism.busy_seen", busy_seen, 0);
        check("mism.stb_cnt", stb_idx_q.size(), 0);
        check_regs("mism");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write("ptr_oob", 8'h10, 2);
        xfer_read("ptr_keep", 1'b0, 8'h00, 1);

        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        xfer_write("ptr_wrap", 8'h0F, 3);
        check("ptr_wrap.reg15", reg_out[15*8 +: 8], 8'h01);
        check("ptr_wrap.reg0", reg_out[0 +: 8], 8'h02);
        check("ptr_wrap.reg1", reg_out[8 +: 8], 8'h03);

        glitch_en = 1'b1;
        wbuf[0] = 8'h96; wbuf[1] = 8'h5E;
        xfer_write("glitch", 8'h07, 2);
        glitch_en = 1'b0;

        clear_mon();
        bus_start();
        write_byte({SLV, 1'b0}, ack);
        check("abort.addr_ack", ack, 0);
        write_byte(8'h02, ack);
        check("abort.ptr_ack", ack, 0);
        mptr = 2;
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_bit(1'b1, s);
        bus_stop();
        wq();
        check("abort.stb_cnt", stb_idx_q.size(), 0);
        check("abort.busy", busy, 0);
        check("abort.sda", sda_bus, 1);
        check_regs("abort");

        for (int k = 0; k < 6; k++) begin
            logic [7:0] p;
            int         n;
            p = 8'($urandom_range(0, 19));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            xfer_write("rnd_wr", p, n);
            xfer_read("rnd_rd", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                      int'($urandom_range(1, 4)));
        end

        wbuf[0] = 8'h3C;
        xfer_write("rst_prep", 8'h05, 1);
        bus_start();
        write_byte({SLV, 1'b0}, ack);
        write_byte(8'h05, ack);
        bus_start();
        write_byte({SLV, 1'b1}, ack);
        check("rst.raddr_ack", ack, 0);
        check("rst.drive0", sda_bus, 0);
        rstn = 1'b0;
        #1;
        check("rst.sda_rel", sda_bus, 1);
        check("rst.reg_out", reg_out, 0);
        check("rst.busy", busy, 0);
        check("rst.wr_stb", wr_stb, 0);
        check("rst.wr_idx", wr_idx, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        bus_stop();
        wq();
        xfer_read("post_rst", 1'b0, 8'h00, 2);

        check("stb_width", stb_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C target that exposes a byte-wide register bank to an external I2C master. It sits on the same `scl`/`sda` bus as `i2c_master` and replaces the fixed-behaviour `i2c_slave`. It adds a configurable device address, a register pointer with auto-increment and wrap, master-ACK/NACK-terminated reads, and a parallel register image with write strobes for on-chip logic. All bus sampling is oversampled in the system clock domain; there is no logic clocked by `scl`.

## Interface
- `SLV_ADDR`, default 7'h2d: 7-bit device address matched on the address byte.
- `REG_NUM`, default 16: number of 8-bit registers, 2..256.
- `SYNC_STAGES`, default 2: synchroniser depth on `scl` and `sda`, minimum 2.
- `FILT_CYC`, default 3: glitch-filter length; a synchronised level must be stable this many `clk` cycles before it is accepted.
- `clk` input 1: system clock; must be at least 20× the SCL rate.
- `rstn` input 1: asynchronous active-low reset.
- `scl` input 1: I2C clock, master-driven; no clock stretching.
- `sda` inout 1: open-drain I2C data; driven low or high-Z only, never driven high.
- `reg_out` output 8*REG_NUM: register image, with reg[i] at bits [8i+7:8i].
- `wr_stb` output 1: one-`clk` pulse per committed register write.
- `wr_idx` output 8: index of the register written, valid while `wr_stb`=1.
- `busy` output 1: high from an addressed START until STOP or mismatch.

## Operation
- **Bus events.** Bus events use the filtered levels `scl_f` and `sda_f`.
  - START: `sda_f` falls while `scl_f`=1.
  - STOP: `sda_f` rises while `scl_f`=1.
  - Data is sampled on a rising edge of `scl_f`.
  - `sda` drive changes only on a falling edge of `scl_f`.
- **FSM states.** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- **IDLE.** START → ADDR.
- **ADDR.** Shifts 8 bits, MSB first.
  - If addr = SLV_ADDR: → ADDR_ACK, drive ACK (low) for the 9th clock, set `busy`.
  - If the R/W bit is 1, the next state is RDATA; otherwise PTR.
  - On mismatch: leave `sda` released → IGNORE.
- **PTR.** Receives the pointer byte.
  - If the value < REG_NUM: ACK, load `ptr`, → WDATA.
  - Otherwise: NACK, `ptr` unchanged, → IGNORE.
- **WDATA.** Receives a byte.
  - On the 8th sampling edge, write reg[ptr], pulse `wr_stb` with `wr_idx`=ptr, then ACK → WDATA.
  - Then `ptr` ← (ptr+1) mod REG_NUM.
- **RDATA.** Shifts out reg[ptr], MSB first. The byte is latched at the falling edge that starts bit 7.
  - `sda` is released for the 9th clock; RACK samples it.
  - Master ACK (0): `ptr` ← (ptr+1) mod REG_NUM → RDATA.
  - Master NACK (1): `ptr` still increments → IGNORE, `sda` released.
- **IGNORE.** Waits for START or STOP; `sda` stays released.
- **START in any state.** Repeated START → ADDR; the shift count is cleared and any partial byte is discarded. `ptr` is kept, so a write-pointer/read sequence works.
- **STOP in any state.** → IDLE, `busy`=0, `sda` released. A partial byte is discarded and nothing is written.
- **Register bank.** Registers are writable only via I2C.
- **Reset values.**
  - `reg_out`=0, `ptr`=0, `wr_stb`=0, `wr_idx`=0, `busy`=0.
  - `sda` is high-Z and the FSM is IDLE.
  - Assertion of `rstn` releases `sda` immediately, without waiting for `clk`.

## Timing
- **Input latency.** `scl`/`sda` edge to filtered edge is SYNC_STAGES+FILT_CYC `clk` cycles. Glitches shorter than FILT_CYC cycles are ignored.
- **Drive latency.** The `sda` drive change occurs 1 `clk` after the filtered SCL falling edge. Worst case from the pad edge is SYNC_STAGES+FILT_CYC+1 cycles, which must be less than tHD;DAT of the master.
- **Write strobe.** `wr_stb` asserts 1 `clk` after the 8th data-bit rising edge is detected and lasts exactly 1 cycle. `reg_out` updates in the same cycle as `wr_stb`.
- **ACK window.** ACK is driven from the falling edge after bit 0 until the next filtered falling edge.
- **busy.** `busy` rises with the ADDR_ACK drive and falls 1 `clk` after STOP or mismatch detection.
- **Pointer wrap.** `ptr` wrap arithmetic is modulo REG_NUM. For non-power-of-two REG_NUM, REG_NUM-1 wraps to 0.

## Test plan
- **Write with auto-increment.** START, 0x5a (0x2d, W), pointer 0x03, data 0xA5, 0x3C, STOP.
  - Three ACKs.
  - reg[3]=0xA5 and reg[4]=0x3C.
  - Two `wr_stb` pulses, with `wr_idx` 3 then 4.
- **Repeated-start read.** START, 0x5a, pointer 0x03, Sr, 0x5b (R), master ACK then NACK.
  - The bus returns 0xA5, 0x3C.
  - `sda` is released after the NACK and `busy`=0 after STOP.
- **Address mismatch.** The address byte is 0xB6 (0x5b, W).
  - NACK; no `wr_stb`; `busy` stays 0.
  - The subsequent bytes are ignored until STOP.
- **Pointer bounds and wrap.** REG_NUM=16.
  - Pointer 0x10 → NACK and `ptr` is unchanged.
  - Pointer 0x0F with data 1,2,3 → reg[15]=1, reg[0]=2, reg[1]=3.
- **Aborted byte.** STOP after 4 data bits of WDATA.
  - No `wr_stb` and registers unchanged.
  - The FSM is IDLE and `sda` is high-Z.
- **Reset during read.** Assert `rstn` while driving a 0 bit in RDATA.
  - `sda` goes high-Z with no `clk` edge.
  - All outputs hold their reset values.
